facto_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one facto unit among NREQ requesters.

---
 rtl/facto_arbiter_if.sv | 26 ++
 rtl/facto_arbiter.sv | 159 +++++++++++++++
 tb/tb_facto_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/facto_arbiter_if.sv
// Requester-side bundle of the facto arbiter: request/operand inputs, grant
// pulses and the per-requester result handshake.
interface facto_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_i;
  logic [NREQ*8-1:0] x_i;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   rsp_valid_o;
  logic [NREQ-1:0]   rsp_ready_i;
  logic [7:0]        rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;

  // Requester clients drive requests, operands and result acceptance.
  modport master (
    output req_i, x_i, rsp_ready_i,
    input  gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
  );

  // The arbiter samples requests and returns grants and results.
  modport slave (
    input  req_i, x_i, rsp_ready_i,
    output gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/facto_arbiter.sv
// Round-robin arbiter sharing a single facto unit among NREQ requesters.
// One job in flight at a time; operand is held on fu_x_o for the whole job,
// the result (or a timeout error) is returned to the owner via valid/ready.
module facto_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic       CLK,
  input  logic       RST,
  facto_arbiter_if.slave bus,
  output logic [7:0] fu_x_o,
  output logic       fu_start_o,
  input  logic       fu_done_i,
  input  logic [7:0] fu_fi_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    BLANK  = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] vld_q, vld_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      x_q, x_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx_p;
  int unsigned     idx;

  // Round-robin pick: first set request scanning upward from ptr+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    idx_p = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx   = (int'(ptr_q) + k) % NREQ;
      idx_p = PW'(idx);
      if (!found && bus.req_i[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
  end

  // Next-state and next-output logic; every output is a register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    vld_d   = vld_q;
    data_d  = data_q;
    x_d     = x_q;
    err_d   = err_q;
    start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << win;
          x_d     = bus.x_i[int'(win)*8 +: 8];
          owner_d = win;
          ptr_d   = win;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        state_d = BLANK;
      end
      // A Done still high from the previous job is deliberately not looked at here.
      BLANK: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (fu_done_i) begin
          data_d  = fu_fi_i;
          err_d   = 1'b0;
          vld_d   = NREQ'(1) << owner_q;
          state_d = RESP;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          vld_d   = NREQ'(1) << owner_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i[owner_q]) begin
          vld_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= '0;
      data_q  <= '0;
      x_q     <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      x_q     <= x_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.rsp_valid_o = vld_q;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.busy_o      = busy_q;
  assign fu_x_o          = x_q;
  assign fu_start_o      = start_q;

endmodule

// File: tb/tb_facto_arbiter.sv
// Self-checking bench for facto_arbiter with a behavioural facto stub.
module tb_facto_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] fu_x_o;
  logic       fu_start_o;
  logic       fu_done_i;
  logic [7:0] fu_fi_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] xv [N];
  logic [3:0] pend;
  int         m_ptr;
  int         stub_lat;
  bit         stub_stale;
  bit         stub_on;
  bit         mon_en;

  always #5 CLK = ~CLK;

  facto_arbiter_if #(.NREQ(N)) bus ();

  facto_arbiter #(.NREQ(N), .TIMEOUT(TO), .TO_W(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .fu_x_o     (fu_x_o),
    .fu_start_o (fu_start_o),
    .fu_done_i  (fu_done_i),
    .fu_fi_i    (fu_fi_i)
  );

  function automatic logic [7:0] fact(input logic [7:0] x);
    int p = 1;
    for (int i = 2; i <= int'(x); i++) p = p * i;
    return 8'(p);
  endfunction

  // Owner choice: the pending requester closest after the last winner.
  function automatic int pick(input int p, input logic [3:0] m);
    int best = -1;
    int bd   = 100;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        int d = (i - p - 1 + 2 * N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // facto stand-in: Done with n! some cycles after each start, optional stale Done in BLANK.
  initial begin
    logic [7:0] sx;
    fu_done_i = 1'b0;
    fu_fi_i   = '0;
    forever begin
      @(posedge CLK); #1;
      if (fu_start_o && stub_on && !RST) begin
        sx = fu_x_o;
        if (stub_stale) begin fu_done_i = 1'b1; fu_fi_i = 8'hEE; end
        for (int i = 0; i < stub_lat; i++) begin @(posedge CLK); #1; fu_done_i = 1'b0; end
        fu_done_i = 1'b1;
        fu_fi_i   = fact(sx);
        @(posedge CLK); #1;
        fu_done_i = 1'b0;
        fu_fi_i   = '0;
      end
    end
  end

  // Cycle-wide invariants on grants and responses.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      check("gnt_vld_exclusive", 32'((|bus.gnt_o) && (|bus.rsp_valid_o)), 0);
      check("gnt_onehot0", 32'($onehot0(bus.gnt_o)), 1);
      check("vld_onehot0", 32'($onehot0(bus.rsp_valid_o)), 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_x();
    bus.x_i = {xv[3], xv[2], xv[1], xv[0]};
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_gnt", bus.gnt_o, 0);
    check("rst_vld", bus.rsp_valid_o, 0);
    check("rst_data", bus.rsp_data_o, 0);
    check("rst_err", bus.rsp_err_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_fu_x", fu_x_o, 0);
    check("rst_start", fu_start_o, 0);
    RST = 1'b0;
    m_ptr = N - 1;
    pend = '0;
    bus.req_i = '0;
    bus.rsp_ready_i = '0;
  endtask

  task automatic do_job(input logic [3:0] add, input int stall, input int lat,
                        input bit stale, input bit son);
    int w, n, starts, exp_lat;
    bit exp_err;
    logic [7:0] exp_d;
    logic [3:0] wm;
    pend |= add;
    bus.req_i = pend;
    drive_x();
    stub_lat = lat; stub_stale = stale; stub_on = son;
    w  = pick(m_ptr, pend);
    wm = 4'b0001 << w;
    @(posedge CLK); #1;
    check("gnt", bus.gnt_o, wm);
    check("fu_x", fu_x_o, xv[w]);
    check("busy_at_grant", bus.busy_o, 1);
    check("start_in_launch", fu_start_o, 0);
    pend[w] = 1'b0;
    bus.req_i = pend;
    m_ptr = w;
    @(posedge CLK); #1;
    check("gnt_pulse_end", bus.gnt_o, 0);
    check("start_pulse", fu_start_o, 1);
    n = 1; starts = 0;
    while (bus.rsp_valid_o == '0 && n < 60) begin
      @(posedge CLK); #1;
      n++;
      if (fu_start_o) starts++;
    end
    exp_err = !(son && lat <= TO);
    exp_lat = exp_err ? 2 + TO : 2 + lat;
    exp_d   = exp_err ? 8'd0 : fact(xv[w]);
    check("rsp_valid", bus.rsp_valid_o, wm);
    check("rsp_data", bus.rsp_data_o, exp_d);
    check("rsp_err", bus.rsp_err_o, exp_err);
    check("latency", n, exp_lat);
    check("extra_starts", starts, 0);
    check("fu_x_held", fu_x_o, xv[w]);
    for (int s = 0; s < stall; s++) begin
      bus.req_i = '1;
      bus.rsp_ready_i = ~wm;
      @(posedge CLK); #1;
      check("stall_gnt", bus.gnt_o, 0);
      check("stall_vld", bus.rsp_valid_o, wm);
      check("stall_data", bus.rsp_data_o, exp_d);
      check("stall_busy", bus.busy_o, 1);
    end
    bus.req_i = pend;
    bus.rsp_ready_i = wm | 4'($urandom_range(0, 15));
    @(posedge CLK); #1;
    check("rel_vld", bus.rsp_valid_o, 0);
    check("rel_err", bus.rsp_err_o, 0);
    check("rel_busy", bus.busy_o, 0);
    check("rel_gnt", bus.gnt_o, 0);
    bus.rsp_ready_i = '0;
  endtask

  initial begin
    logic [3:0] add;
    int lat;
    bus.req_i = '0; bus.x_i = '0; bus.rsp_ready_i = '0;
    for (int i = 0; i < N; i++) xv[i] = '0;
    pend = '0; m_ptr = N - 1;
    stub_lat = 1; stub_stale = 0; stub_on = 1; mon_en = 0;

    do_reset();
    mon_en = 1;

    // single request
    xv[0] = 8'd5;
    do_job(4'b0001, 0, 2, 0, 1);

    // all four from reset: order 0,1,2,3
    do_reset();
    xv[3] = 8'd4; xv[2] = 8'd3; xv[1] = 8'd2; xv[0] = 8'd5;
    do_job(4'b1111, 0, 1, 0, 1);
    do_job(4'b0000, 0, 3, 0, 1);
    do_job(4'b0000, 1, 2, 0, 1);
    do_job(4'b0000, 0, 4, 0, 1);

    // wrap: serve 2, then 0101 grants 0 before 2
    xv[2] = 8'd1;
    do_job(4'b0100, 0, 1, 0, 1);
    xv[0] = 8'd3; xv[2] = 8'd4;
    do_job(4'b0101, 0, 2, 0, 1);
    do_job(4'b0000, 0, 2, 0, 1);

    // backpressure with all requests asserted
    xv[1] = 8'd4;
    do_job(4'b0010, 10, 3, 0, 1);

    // timeout, Done on the last WAIT cycle, Done one cycle too late, stale Done
    xv[0] = 8'd5;
    do_job(4'b0001, 0, 0, 0, 0);
    do_job(4'b0001, 0, TO, 0, 1);
    do_job(4'b0001, 0, TO + 1, 0, 1);
    xv[2] = 8'd3;
    do_job(4'b0100, 0, 3, 1, 1);

    // reset while in WAIT
    xv[0] = 8'd4;
    pend = 4'b0001; bus.req_i = pend; drive_x(); stub_on = 0;
    @(posedge CLK); #1;
    check("rw_gnt", bus.gnt_o, 4'b0001);
    pend = '0; bus.req_i = '0;
    repeat (4) begin @(posedge CLK); #1; end
    check("rw_busy", bus.busy_o, 1);
    #2 RST = 1'b1;
    #1;
    check("rw_async_busy", bus.busy_o, 0);
    check("rw_async_gnt", bus.gnt_o, 0);
    check("rw_async_vld", bus.rsp_valid_o, 0);
    check("rw_async_fu_x", fu_x_o, 0);
    check("rw_async_start", fu_start_o, 0);
    do_reset();
    xv[0] = 8'd2; xv[3] = 8'd3;
    do_job(4'b1001, 0, 2, 0, 1);
    do_job(4'b0000, 0, 1, 0, 1);

    // randomized traffic
    for (int j = 0; j < 30; j++) begin
      add = 4'($urandom_range(0, 15));
      if ((pend | add) == '0) add = 4'b0001 << $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++)
        if (add[i] && !pend[i]) xv[i] = 8'($urandom_range(0, 5));
      lat = $urandom_range(1, 6);
      do_job(add, $urandom_range(0, 3), lat, bit'($urandom_range(0, 1)), 1);
    end

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
